// File: rtl/rs_syndrome_checker.sv
// Purpose : RS(255,249) receive-side syndrome checker over GF(2^8) (poly 0x11D, alpha=0x02).
//           It computes S1..S6, flags corrupted words and forwards the 249 message symbols.
// Latency : the message passes through in 1 cycle. With RS_CHECK_BUFFER_EN defined, the
//           message is replayed starting the cycle after the done pulse.
// Backpr. : there is no ready signal. Gaps in rx_valid stall the word, and there is no timeout.
//
// Build option: `define RS_CHECK_BUFFER_EN adds a 249x8 message store and a REPLAY state.
//           The store lets downstream see err before it receives any message symbol.
//
// Ports:
//   clk, rst_n       rising-edge clock; asynchronous active-low reset
//   start            begin a codeword (sampled in IDLE only)
//   stop             synchronous abort to IDLE (beats everything but rst_n)
//   RX, rx_valid     received symbol stream, highest degree first (honoured in RECV only)
//   MX_out, mx_valid recovered message symbols
//   syn, err, done   {S6..S1}, nonzero flag, one-cycle valid pulse
//   busy             high whenever not IDLE
module rs_syndrome_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  RX,
    input  logic        rx_valid,
    output logic [7:0]  MX_out,
    output logic        mx_valid,
    output logic [47:0] syn,
    output logic        err,
    output logic        done,
    output logic        busy
);

`ifdef RS_CHECK_BUFFER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_CHECK = 2'd2, S_REPLAY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_CHECK = 2'd2} state_t;
`endif

    localparam logic [7:0] LAST_IDX = 8'd254;
    localparam logic [7:0] MSG_LEN  = 8'd249;

    // Multiply by alpha. This is a shift plus a conditional fold of the 0x1D reduction term.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by alpha^p for a constant p. After unrolling, this becomes a fixed XOR network.
    function automatic logic [7:0] gf_mul_apow(input logic [7:0] a, input int p);
        logic [7:0] r;
        r = a;
        for (int k = 0; k < p; k++) r = gf_xtime(r);
        return r;
    endfunction

    state_t          state;
    logic [7:0]      cnt;
    logic [5:0][7:0] s_q;     // s_q[j] holds S(j+1), so s_q packs to {S6..S1}
    logic [5:0][7:0] s_step;  // Horner update with the current RX folded in

    always_comb begin
        s_step = '0;
        for (int j = 0; j < 6; j++) begin
            s_step[j] = gf_mul_apow(s_q[j], j + 1) ^ RX;
        end
    end

    assign busy = (state != S_IDLE);

`ifdef RS_CHECK_BUFFER_EN
    logic [7:0] mem [0:248];
    logic [7:0] rd;

    // The message store has no reset. Only locations written in this word are ever read back.
    always_ff @(posedge clk) begin
        if (state == S_RECV && rx_valid && !stop && cnt < MSG_LEN) begin
            mem[cnt] <= RX;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            s_q      <= '0;
            MX_out   <= '0;
            mx_valid <= 1'b0;
            syn      <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
`ifdef RS_CHECK_BUFFER_EN
            rd       <= '0;
`endif
        end else if (stop) begin
            // An abort leaves the previously latched syn and err visible.
            state    <= S_IDLE;
            cnt      <= '0;
            s_q      <= '0;
            mx_valid <= 1'b0;
            done     <= 1'b0;
`ifdef RS_CHECK_BUFFER_EN
            rd       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    mx_valid <= 1'b0;
                    if (start) begin
                        state <= S_RECV;
                        cnt   <= '0;
                        s_q   <= '0;
                        syn   <= '0;
                        err   <= 1'b0;
                    end
                end
                S_RECV: begin
                    mx_valid <= 1'b0;
                    if (rx_valid) begin
                        s_q <= s_step;
                        cnt <= cnt + 8'd1;
`ifndef RS_CHECK_BUFFER_EN
                        if (cnt < MSG_LEN) begin
                            MX_out   <= RX;
                            mx_valid <= 1'b1;
                        end
`endif
                        // Latch the result on the same edge that takes the last symbol.
                        // This makes done, syn and err valid together during the CHECK cycle.
                        if (cnt == LAST_IDX) begin
                            state <= S_CHECK;
                            syn   <= s_step;
                            err   <= |s_step;
                            done  <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    done <= 1'b0;
`ifdef RS_CHECK_BUFFER_EN
                    MX_out   <= mem[0];
                    mx_valid <= 1'b1;
                    rd       <= 8'd1;
                    state    <= S_REPLAY;
`else
                    mx_valid <= 1'b0;
                    state    <= S_IDLE;
`endif
                end
`ifdef RS_CHECK_BUFFER_EN
                S_REPLAY: begin
                    if (rd == MSG_LEN) begin
                        mx_valid <= 1'b0;
                        rd       <= '0;
                        state    <= S_IDLE;
                    end else begin
                        MX_out <= mem[rd];
                        rd     <= rd + 8'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_checker.sv
// Purpose : directed self-checking bench for rs_syndrome_checker (works in either build).
// Latency : message symbols are checked by collecting every mx_valid beat and comparing the list.
// Backpr. : none. Every wait on the DUT has a cycle budget.
module tb_rs_syndrome_checker;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, rx_valid;
    logic [7:0]  RX;
    logic [7:0]  MX_out;
    logic        mx_valid, err, done, busy;
    logic [47:0] syn;

    rs_syndrome_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .RX(RX), .rx_valid(rx_valid),
        .MX_out(MX_out), .mx_valid(mx_valid),
        .syn(syn), .err(err), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] cw [0:254];
    logic [7:0] mxq [$];

    // Error value 1 at degree 6 gives S_j = alpha^(6j). The values are {S6..S1}.
    localparam logic [47:0] SYN_DEG6 = {8'h25, 8'h60, 8'h8F, 8'h2D, 8'hCD, 8'h40};
    localparam logic [47:0] SYN_ONES = 48'h01_01_01_01_01_01;

    always @(negedge clk) begin
        if (mx_valid) mxq.push_back(MX_out);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Codeword equal to the generator polynomial: message x^6, parity 126,4,158,58,49,117.
    task automatic set_valid();
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
        cw[248] = 8'h01;
        cw[249] = 8'd126; cw[250] = 8'd4;  cw[251] = 8'd158;
        cw[252] = 8'd58;  cw[253] = 8'd49; cw[254] = 8'd117;
    endtask

    task automatic do_start();
        mxq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 48'(busy), 48'd1);
        chk("start_err_cleared", 48'(err), 48'd0);
        chk("start_syn_cleared", syn, 48'd0);
    endtask

    task automatic send(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                rx_valid = 1'b0;
                RX       = 8'hAA;
                tick();
            end
            rx_valid = 1'b1;
            RX       = cw[i];
            tick();
            if (i == 248) begin
`ifdef RS_CHECK_BUFFER_EN
                chk("recv_mx_held_back", 48'(mx_valid), 48'd0);
`else
                chk("pass_last_msg_vld", 48'(mx_valid), 48'd1);
                chk("pass_last_msg_dat", 48'(MX_out), 48'(cw[248]));
`endif
            end
            if (i == 249) chk("parity_not_forwarded", 48'(mx_valid), 48'd0);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_word(input string tag, input bit gaps, input logic [47:0] esyn, input logic eerr);
        int d0;
        int bad;
        d0 = done_cnt;
        do_start();
        send(0, 254, gaps);
        @(negedge clk);
        chk({tag, "_done"}, 48'(done), 48'd1);
        chk({tag, "_syn"}, syn, esyn);
        chk({tag, "_err"}, 48'(err), 48'(eerr));
        tick();
        @(negedge clk);
        chk({tag, "_done_pulse"}, 48'(done), 48'd0);
        for (int c = 0; c < 600 && busy; c++) tick();
        chk({tag, "_idle"}, 48'(busy), 48'd0);
        chk({tag, "_done_count"}, 48'(done_cnt - d0), 48'd1);
        chk({tag, "_mx_count"}, 48'(mxq.size()), 48'd249);
        bad = 0;
        for (int i = 0; i < 249 && i < mxq.size(); i++) if (mxq[i] !== cw[i]) bad++;
        chk({tag, "_mx_content_bad"}, 48'(bad), 48'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; rx_valid = 1'b0; RX = 8'h00;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mx_out", 48'(MX_out), 48'd0);
        chk("rst_mx_valid", 48'(mx_valid), 48'd0);
        chk("rst_syn", syn, 48'd0);
        chk("rst_err", 48'(err), 48'd0);
        chk("rst_done", 48'(done), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
        run_word("zero", 1'b0, 48'd0, 1'b0);

        set_valid();
        run_word("valid", 1'b0, 48'd0, 1'b0);

        set_valid();
        cw[254] = 8'd116;
        run_word("last116", 1'b0, SYN_ONES, 1'b1);

        set_valid();
        cw[248] = 8'h00;
        run_word("deg6", 1'b0, SYN_DEG6, 1'b1);

        set_valid();
        run_word("gaps", 1'b1, 48'd0, 1'b0);

        // Rebuild the degree-6 error result, then abort the next word at symbol 100.
        set_valid();
        cw[248] = 8'h00;
        run_word("deg6b", 1'b0, SYN_DEG6, 1'b1);
        d0 = done_cnt;
        do_start();
        send(0, 99, 1'b0);
        stop     = 1'b1;
        rx_valid = 1'b1;
        RX       = cw[100];
        tick();
        stop     = 1'b0;
        chk("stop_busy", 48'(busy), 48'd0);
        chk("stop_done", 48'(done), 48'd0);
        chk("stop_mx_valid", 48'(mx_valid), 48'd0);
        chk("stop_err_held", 48'(err), 48'd0);
        chk("stop_syn_held", syn, 48'd0);
        for (int i = 101; i < 255; i++) begin
            RX = cw[i];
            tick();
        end
        rx_valid = 1'b0;
        chk("stop_stays_idle", 48'(busy), 48'd0);
        chk("stop_no_done", 48'(done_cnt - d0), 48'd0);

        // Reset the word asynchronously while mx_valid is high.
        set_valid();
        cw[254] = 8'd116;
        do_start();
`ifdef RS_CHECK_BUFFER_EN
        send(0, 254, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        chk("pre_reset_err", 48'(err), 48'd1);
`else
        send(0, 199, 1'b0);
`endif
        chk("pre_reset_mx_valid", 48'(mx_valid), 48'd1);
        chk("pre_reset_busy", 48'(busy), 48'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_mx_out", 48'(MX_out), 48'd0);
        chk("arst_mx_valid", 48'(mx_valid), 48'd0);
        chk("arst_syn", syn, 48'd0);
        chk("arst_err", 48'(err), 48'd0);
        chk("arst_done", 48'(done), 48'd0);
        chk("arst_busy", 48'(busy), 48'd0);
        tick();
        rst_n = 1'b1;
        tick();

        set_valid();
        run_word("fresh", 1'b0, 48'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_checker.md
# rs_syndrome_checker

Receive-side companion to the RS(255,249) encoder: accepts a 255-symbol codeword over GF(2^8), computes the six syndromes S1..S6, flags any uncorrectable-or-corrupted word, and forwards the 249 message symbols downstream. It is the detection front end of the decoder path and sits between the channel interface and any later correction stage.

## Interface
- Parameters: none. The field, code and generator are fixed. Field polynomial is x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. Generator roots are α^1..α^6, which gives coefficients 117, 49, 58, 158, 4, 126.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a codeword; sampled only in IDLE.
- stop  in  1  synchronous abort to IDLE; has priority over everything except rst_n.
- RX  in  8  received symbol, highest degree first: 249 message symbols, then parity in encoder output order (X5..X0).
- rx_valid  in  1  RX is valid this cycle; honoured only in RECV.
- MX_out  out  8  recovered message symbol.
- mx_valid  out  1  MX_out valid this cycle.
- syn  out  48  {S6,S5,S4,S3,S2,S1}, each 8 bits; valid when done pulses, held until next start.
- err  out  1  1 if any syndrome is nonzero; valid when done pulses, held until next start.
- done  out  1  one-cycle pulse when syn and err become valid.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: start=1 → RECV, and syndromes, counter and err are cleared on that edge.
  - RECV: each cycle with rx_valid=1 accepts one symbol. Update rule: S_j ← (S_j · α^j) ⊕ RX, for j = 1..6 (Horner). An 8-bit counter increments per accepted symbol. On acceptance of symbol index 254 → CHECK.
  - CHECK: err ← OR of all syndrome bits; syn is latched; done=1 for this one cycle. Next state is REPLAY if the buffer is compiled in, otherwise IDLE.
  - REPLAY (buffer build only): emits buffered symbols 0..248 on consecutive cycles, then → IDLE.
- GF multiplies are by constants α^1..α^6 only, implemented as fixed XOR networks. There are no general multipliers.
- Gaps in rx_valid during RECV stall the counter and syndromes; no timeout.
- start outside IDLE is ignored. rx_valid outside RECV is ignored and the symbol is dropped.
- stop in any state → IDLE next edge. It clears counter, syndromes, mx_valid and done. It does not pulse done, and leaves err/syn at their previous latched values. If stop and start are both high, stop wins.
- Reset mid-word: immediate return to IDLE with all outputs 0.
- Reset values: MX_out=0, mx_valid=0, syn=0, err=0, done=0, busy=0.

## Timing
- Symbol accepted on edge k ⇒ syndromes reflect it after edge k.
- CHECK is entered on the edge that accepts symbol 254. done is high the following cycle.
- With buffer: mx_valid is high for exactly 249 consecutive cycles, starting the cycle after done. Symbols are output in receive order.
- Without buffer: a message symbol (index 0..248) accepted on edge k appears on MX_out with mx_valid=1 after edge k. Parity symbols (249..254) never assert mx_valid.
- Minimum codeword-to-codeword spacing:
  - Without buffer: 257 cycles (start + 255 + CHECK).
  - With buffer: 506 cycles.

## Configuration
- RS_CHECK_BUFFER_EN defined:
  - Adds a 249×8 storage array and the REPLAY state.
  - Message symbols are released only after err is known, so downstream can discard a bad word before it consumes any data.
- Undefined:
  - No storage and no REPLAY state.
  - Message symbols pass through at 1-cycle latency, and err arrives after the last one.
- Syndrome and err behaviour is identical in both builds.

## Test plan
- All-zero codeword (start, 255 × 0x00) → syn=0, err=0, done one cycle after symbol 254. With buffer: 249 × 0x00 on MX_out.
- Valid codeword: 248 × 0x00, 0x01, then 126, 4, 158, 58, 49, 117 → syn=0, err=0. MX_out sequence is 248 × 0x00 followed by 0x01.
- Same codeword with the last symbol changed from 117 to 116 → S1..S6 all = 0x01, err=1.
- Same codeword with symbol 248 changed from 0x01 to 0x00 (error value 1 at degree 6):
  - S1=α^6=0x40, S2=α^12=0xCD, S3=α^18=0x2D, S4=α^24, S5=α^30, S6=α^36; err=1.
- rx_valid toggling every other cycle over the valid codeword → same result as the gapless case. done occurs after the 255th accepted symbol.
- Abort and reset: stop asserted at symbol 100 → IDLE, no done, busy=0. rst_n pulsed low during REPLAY → all outputs 0 immediately. A fresh codeword afterward decodes correctly.
